// File: rtl/e203_exu_oitf_pkg.sv
// Shared widths and the per-entry payload type for the outstanding
// instruction track FIFO (OITF) and its entry cells.
package e203_exu_oitf_pkg;

    localparam int E203_OITF_DEPTH  = 2;
    localparam int E203_ITAG_WIDTH  = 1;
    localparam int E203_RFIDX_WIDTH = 5;
    localparam int E203_PC_SIZE     = 32;

    typedef struct packed {
        logic                        rdwen;
        logic [E203_RFIDX_WIDTH-1:0] rdidx;
        logic [E203_PC_SIZE-1:0]     pc;
    } oitf_ent_t;

    // Smallest pointer width that can address every entry.
    function automatic int oitf_ptr_w(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/e203_exu_oitf_entry.sv
// One OITF slot: valid bit, captured payload and the hazard comparators.
// Match outputs are raw; the source/rd enables are applied in the top.
module e203_exu_oitf_entry
    import e203_exu_oitf_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alc,
    input  logic                        ret,
    input  oitf_ent_t                   ent_in,
    input  logic [E203_RFIDX_WIDTH-1:0] rs1idx,
    input  logic [E203_RFIDX_WIDTH-1:0] rs2idx,
    input  logic [E203_RFIDX_WIDTH-1:0] rs3idx,
    input  logic [E203_RFIDX_WIDTH-1:0] rdidx,
    output oitf_ent_t                   ent,
    output logic                        match_rs1,
    output logic                        match_rs2,
    output logic                        match_rs3,
    output logic                        match_rd
);

    logic vld;
    logic live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
        end else if (alc) begin
            vld <= 1'b1;
        end else if (ret) begin
            vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent <= '0;
        end else if (alc) begin
            ent <= ent_in;
        end
    end

    // Registered state only: a retiring entry still matches this cycle,
    // an allocating one does not match until it is written.
    assign live      = vld & ent.rdwen;
    assign match_rs1 = live & (ent.rdidx == rs1idx);
    assign match_rs2 = live & (ent.rdidx == rs2idx);
    assign match_rs3 = live & (ent.rdidx == rs3idx);
    assign match_rd  = live & (ent.rdidx == rdidx);

endmodule

// File: rtl/e203_exu_oitf.sv
// Outstanding instruction track FIFO for the long pipes: circular buffer
// with wrap-flag full/empty detection, zero-latency head read, hazard flags.
module e203_exu_oitf
    import e203_exu_oitf_pkg::*;
#(
    parameter int E203_OITF_DEPTH = e203_exu_oitf_pkg::E203_OITF_DEPTH,
    parameter int E203_ITAG_WIDTH = e203_exu_oitf_pkg::E203_ITAG_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        dis_ena,
    output logic                        dis_ready,
    output logic [E203_ITAG_WIDTH-1:0]  dis_ptr,

    input  logic                        disp_i_rdwen,
    input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rdidx,
    input  logic [E203_PC_SIZE-1:0]     disp_i_pc,
    input  logic                        disp_i_rs1en,
    input  logic                        disp_i_rs2en,
    input  logic                        disp_i_rs3en,
    input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rs1idx,
    input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rs2idx,
    input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rs3idx,

    output logic                        oitfrd_match_disprs1,
    output logic                        oitfrd_match_disprs2,
    output logic                        oitfrd_match_disprs3,
    output logic                        oitfrd_match_disprd,

    input  logic                        ret_ena,
    output logic [E203_ITAG_WIDTH-1:0]  ret_ptr,
    output logic [E203_RFIDX_WIDTH-1:0] ret_rdidx,
    output logic                        ret_rdwen,
    output logic [E203_PC_SIZE-1:0]     ret_pc,

    output logic                        oitf_empty
);

    localparam int DEPTH = E203_OITF_DEPTH;
    localparam int W     = E203_ITAG_WIDTH;
    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    logic [W-1:0] alc_ptr_r;
    logic [W-1:0] ret_ptr_r;
    logic         alc_flg_r;
    logic         ret_flg_r;
    logic         full;
    logic         alc_ok;
    logic         ret_ok;

    oitf_ent_t            ent_in;
    oitf_ent_t [DEPTH-1:0] ent;
    logic [DEPTH-1:0]     m_rs1;
    logic [DEPTH-1:0]     m_rs2;
    logic [DEPTH-1:0]     m_rs3;
    logic [DEPTH-1:0]     m_rd;

    assign full       = (alc_ptr_r == ret_ptr_r) & (alc_flg_r != ret_flg_r);
    assign oitf_empty = (alc_ptr_r == ret_ptr_r) & (alc_flg_r == ret_flg_r);
    // Readiness looks at registered occupancy only, so a slot freed by a
    // same-cycle retire becomes allocatable one cycle later.
    assign dis_ready  = ~full;
    assign alc_ok     = dis_ena & ~full;
    assign ret_ok     = ret_ena & ~oitf_empty;
    assign dis_ptr    = alc_ptr_r;
    assign ret_ptr    = ret_ptr_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alc_ptr_r <= '0;
            alc_flg_r <= 1'b0;
        end else if (alc_ok) begin
            if (alc_ptr_r == LAST) begin
                alc_ptr_r <= '0;
                alc_flg_r <= ~alc_flg_r;
            end else begin
                alc_ptr_r <= alc_ptr_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_ptr_r <= '0;
            ret_flg_r <= 1'b0;
        end else if (ret_ok) begin
            if (ret_ptr_r == LAST) begin
                ret_ptr_r <= '0;
                ret_flg_r <= ~ret_flg_r;
            end else begin
                ret_ptr_r <= ret_ptr_r + 1'b1;
            end
        end
    end

    assign ent_in.rdwen = disp_i_rdwen;
    assign ent_in.rdidx = disp_i_rdidx;
    assign ent_in.pc    = disp_i_pc;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        e203_exu_oitf_entry u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .alc       (alc_ok & (alc_ptr_r == W'(i))),
            .ret       (ret_ok & (ret_ptr_r == W'(i))),
            .ent_in    (ent_in),
            .rs1idx    (disp_i_rs1idx),
            .rs2idx    (disp_i_rs2idx),
            .rs3idx    (disp_i_rs3idx),
            .rdidx     (disp_i_rdidx),
            .ent       (ent[i]),
            .match_rs1 (m_rs1[i]),
            .match_rs2 (m_rs2[i]),
            .match_rs3 (m_rs3[i]),
            .match_rd  (m_rd[i])
        );
    end

    assign oitfrd_match_disprs1 = disp_i_rs1en & (|m_rs1);
    assign oitfrd_match_disprs2 = disp_i_rs2en & (|m_rs2);
    assign oitfrd_match_disprs3 = disp_i_rs3en & (|m_rs3);
    assign oitfrd_match_disprd  = disp_i_rdwen & (|m_rd);

    assign ret_rdidx = ent[ret_ptr_r].rdidx;
    assign ret_rdwen = ent[ret_ptr_r].rdwen;
    assign ret_pc    = ent[ret_ptr_r].pc;

    // The writeback arbiter must never retire from an empty FIFO.
    ret_on_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(ret_ena && oitf_empty));

endmodule

// File: tb/tb_e203_exu_oitf.sv
// Directed bench for e203_exu_oitf: scoreboard queue of allocated entries,
// popped and compared against the head outputs when retired.
module tb_e203_exu_oitf;
    import e203_exu_oitf_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dis_ena = 1'b0;
    logic        dis_ready;
    logic [0:0]  dis_ptr;
    logic        disp_i_rdwen = 1'b0;
    logic [4:0]  disp_i_rdidx = '0;
    logic [31:0] disp_i_pc = '0;
    logic        disp_i_rs1en = 1'b0, disp_i_rs2en = 1'b0, disp_i_rs3en = 1'b0;
    logic [4:0]  disp_i_rs1idx = '0, disp_i_rs2idx = '0, disp_i_rs3idx = '0;
    logic        m1, m2, m3, md;
    logic        ret_ena = 1'b0;
    logic [0:0]  ret_ptr;
    logic [4:0]  ret_rdidx;
    logic        ret_rdwen;
    logic [31:0] ret_pc;
    logic        oitf_empty;

    e203_exu_oitf #(.E203_OITF_DEPTH(2), .E203_ITAG_WIDTH(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
        .disp_i_rdwen(disp_i_rdwen), .disp_i_rdidx(disp_i_rdidx), .disp_i_pc(disp_i_pc),
        .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rs3en(disp_i_rs3en),
        .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rs3idx(disp_i_rs3idx),
        .oitfrd_match_disprs1(m1), .oitfrd_match_disprs2(m2),
        .oitfrd_match_disprs3(m3), .oitfrd_match_disprd(md),
        .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx),
        .ret_rdwen(ret_rdwen), .ret_pc(ret_pc), .oitf_empty(oitf_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdwen;
        logic [4:0]  rdidx;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   alc_m = 0;
    int   ret_m = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_match(input string tag, input logic e1, input logic e2,
                             input logic e3, input logic ed);
        chk({tag, ".rs1"}, 64'(m1), 64'(e1));
        chk({tag, ".rs2"}, 64'(m2), 64'(e2));
        chk({tag, ".rs3"}, 64'(m3), 64'(e3));
        chk({tag, ".rd"},  64'(md), 64'(ed));
    endtask

    // Drive one cycle's dispatch/retire request and check pre-edge outputs.
    task automatic drive(input string tag, input logic d, input logic r,
                         input logic wen, input logic [4:0] idx, input logic [31:0] pc);
        dis_ena = d; ret_ena = r;
        disp_i_rdwen = wen; disp_i_rdidx = idx; disp_i_pc = pc;
        #1;
        chk({tag, ".dis_ptr"}, 64'(dis_ptr), 64'(alc_m));
        chk({tag, ".dis_ready"}, 64'(dis_ready), 64'(q.size() != DEPTH));
        chk({tag, ".empty"}, 64'(oitf_empty), 64'(q.size() == 0));
        if (q.size() > 0) begin
            chk({tag, ".ret_ptr"}, 64'(ret_ptr), 64'(ret_m));
            chk({tag, ".ret_rdidx"}, 64'(ret_rdidx), 64'(q[0].rdidx));
            chk({tag, ".ret_rdwen"}, 64'(ret_rdwen), 64'(q[0].rdwen));
            chk({tag, ".ret_pc"}, 64'(ret_pc), 64'(q[0].pc));
        end
    endtask

    // Take the edge and advance the scoreboard the way the FIFO should.
    task automatic clock();
        exp_t e;
        bit   do_alc, do_ret;
        do_alc = dis_ena && (q.size() != DEPTH);
        do_ret = ret_ena && (q.size() != 0);
        e.rdwen = disp_i_rdwen; e.rdidx = disp_i_rdidx; e.pc = disp_i_pc;
        @(posedge clk);
        if (do_ret) begin
            void'(q.pop_front());
            ret_m = (ret_m + 1) % DEPTH;
        end
        if (do_alc) begin
            q.push_back(e);
            alc_m = (alc_m + 1) % DEPTH;
        end
        #1;
        dis_ena = 1'b0; ret_ena = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst.empty", 64'(oitf_empty), 64'd1);
        chk("rst.ready", 64'(dis_ready), 64'd1);
        chk("rst.dis_ptr", 64'(dis_ptr), 64'd0);
        chk("rst.ret_ptr", 64'(ret_ptr), 64'd0);
        chk("rst.ret_rdidx", 64'(ret_rdidx), 64'd0);
        chk("rst.ret_rdwen", 64'(ret_rdwen), 64'd0);
        chk("rst.ret_pc", 64'(ret_pc), 64'd0);
        chk_match("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle.empty", 64'(oitf_empty), 64'd1);
        chk_match("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        drive("a0", 1, 0, 1, 5'd5, 32'h100); clock();
        drive("a1", 1, 0, 1, 5'd7, 32'h104); clock();
        chk("full.ready", 64'(dis_ready), 64'd0);
        chk("full.ret_rdidx", 64'(ret_rdidx), 64'd5);
        chk("full.ret_pc", 64'(ret_pc), 64'h100);

        disp_i_rs1en = 1; disp_i_rs1idx = 5'd5;
        disp_i_rs2en = 0; disp_i_rs2idx = 5'd5;
        disp_i_rs3en = 1; disp_i_rs3idx = 5'd7;
        disp_i_rdwen = 1; disp_i_rdidx = 5'd7;
        #1 chk_match("haz", 1'b1, 1'b0, 1'b1, 1'b1);

        // Full plus retire plus dispatch: only the retire lands.
        drive("fr", 1, 1, 1, 5'd7, 32'h108);
        chk_match("fr", 1'b1, 1'b0, 1'b1, 1'b1);
        clock();
        chk("fr_n.ready", 64'(dis_ready), 64'd1);
        chk("fr_n.dis_ptr", 64'(dis_ptr), 64'd0);
        disp_i_rdwen = 0;
        #1 chk_match("fr_n", 1'b0, 1'b0, 1'b1, 1'b0);

        // Same-cycle allocate and retire; the new entry must not match yet.
        disp_i_rs1idx = 5'd9;
        drive("ar", 1, 1, 1, 5'd9, 32'h108);
        chk("ar.m1", 64'(m1), 64'd0);
        clock();
        chk("ar_n.empty", 64'(oitf_empty), 64'd0);
        chk("ar_n.ret_ptr", 64'(ret_ptr), 64'd0);
        disp_i_rdwen = 0;
        #1 chk_match("ar_n", 1'b1, 1'b0, 1'b0, 1'b0);

        drive("x0", 1, 0, 1, 5'd0, 32'h10c); clock();
        disp_i_rs2en = 1; disp_i_rs2idx = 5'd0; disp_i_rdwen = 0;
        #1 chk("x0.m2", 64'(m2), 64'd1);

        drive("ovf", 1, 0, 1, 5'd12, 32'h110); clock();
        drive("r9", 0, 1, 0, 5'd0, 32'h0); clock();
        drive("nw", 1, 0, 0, 5'd3, 32'h114); clock();
        disp_i_rs1idx = 5'd3; disp_i_rdwen = 1; disp_i_rdidx = 5'd3;
        #1 chk_match("nw", 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with two entries outstanding.
        chk("pre_rst.ready", 64'(dis_ready), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.empty", 64'(oitf_empty), 64'd1);
        chk("arst.ready", 64'(dis_ready), 64'd1);
        chk("arst.dis_ptr", 64'(dis_ptr), 64'd0);
        chk("arst.ret_ptr", 64'(ret_ptr), 64'd0);
        chk("arst.ret_rdidx", 64'(ret_rdidx), 64'd0);
        chk("arst.ret_pc", 64'(ret_pc), 64'd0);
        chk_match("arst", 1'b0, 1'b0, 1'b0, 1'b0);
        q.delete(); alc_m = 0; ret_m = 0;
        #1 rst_n = 1'b1;
        disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs3en = 0;
        @(posedge clk); #1;

        drive("p0", 1, 0, 1, 5'd4, 32'h200); clock();
        drive("p1", 0, 1, 0, 5'd0, 32'h0); clock();
        #1 chk("end.empty", 64'(oitf_empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
